// File: rtl/sal_bk_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sal_bk_ctrl_if                                                |
// | Purpose  : Bundles the access, refresh and scheduler handshakes of one   |
// |            DDR2 bank controller.                                         |
// | Ports    : req_valid/req_wr/req_row/req_ready - access from decoder      |
// |            ref_req_in/ref_ack                 - refresh from timer       |
// |            {act,rd,wr,pre,ref}_req/_gnt, act_row - scheduler handshake   |
// | Modports : slave  - the bank controller                                 |
// |            master - the decoder/refresh timer/scheduler side             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface sal_bk_ctrl_if #(
  parameter int ROW_AW = 14
);
  logic              req_valid;
  logic              req_wr;
  logic [ROW_AW-1:0] req_row;
  logic              req_ready;
  logic              ref_req_in;
  logic              ref_ack;
  logic              act_req;
  logic              rd_req;
  logic              wr_req;
  logic              pre_req;
  logic              ref_req;
  logic              act_gnt;
  logic              rd_gnt;
  logic              wr_gnt;
  logic              pre_gnt;
  logic              ref_gnt;
  logic [ROW_AW-1:0] act_row;

  modport slave (
    input  req_valid, req_wr, req_row, ref_req_in,
    input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
    output req_ready, ref_ack,
    output act_req, rd_req, wr_req, pre_req, ref_req, act_row
  );

  modport master (
    output req_valid, req_wr, req_row, ref_req_in,
    output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
    input  req_ready, ref_ack,
    input  act_req, rd_req, wr_req, pre_req, ref_req, act_row
  );
endinterface
`default_nettype wire

// File: rtl/sal_bk_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sal_bk_ctrl                                                   |
// | Purpose  : Per-bank DDR2 state machine. Tracks open/closed state and the |
// |            open row, enforces bank-local timing and raises at most one   |
// |            command request toward the scheduler, held until granted.     |
// | Ports    : clk   - clock                                                 |
// |            rst_n - asynchronous active-low reset                         |
// |            bk    - sal_bk_ctrl_if.slave (access, refresh, scheduler)     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sal_bk_ctrl #(
  parameter int ROW_AW = 14,
  parameter int T_RCD  = 3,
  parameter int T_RAS  = 8,
  parameter int T_RP   = 3,
  parameter int T_RTP  = 2,
  parameter int T_WTP  = 6,
  parameter int T_RFC  = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  sal_bk_ctrl_if.slave  bk
);

  typedef enum logic [2:0] {
    ST_CLOSED     = 3'd0,
    ST_OPENING    = 3'd1,
    ST_OPEN       = 3'd2,
    ST_CLOSING    = 3'd3,
    ST_REFRESHING = 3'd4
  } state_t;

  // Wide enough for the largest timing value regardless of parameterisation.
  localparam int TMR_W = $clog2(T_RCD + T_RAS + T_RP + T_RTP + T_WTP + T_RFC + 1);

  // A grant in cycle N loads T-1 at N+1, so the counter reads 0 at N+T.
  localparam logic [TMR_W-1:0] LD_RCD = TMR_W'(T_RCD - 1);
  localparam logic [TMR_W-1:0] LD_RAS = TMR_W'(T_RAS - 1);
  localparam logic [TMR_W-1:0] LD_RP  = TMR_W'(T_RP  - 1);
  localparam logic [TMR_W-1:0] LD_RTP = TMR_W'(T_RTP - 1);
  localparam logic [TMR_W-1:0] LD_WTP = TMR_W'(T_WTP - 1);
  localparam logic [TMR_W-1:0] LD_RFC = TMR_W'(T_RFC - 1);

  state_t            state_q, state_d, state_eff;
  logic [ROW_AW-1:0] open_row_q, open_row_d;
  logic [TMR_W-1:0]  rcd_q, rcd_d, ras_q, ras_d, rp_q, rp_d;
  logic [TMR_W-1:0]  rtp_q, rtp_d, wtp_q, wtp_d, rfc_q, rfc_d;

  logic act_req, rd_req, wr_req, pre_req, ref_req;
  logic act_fire, rd_fire, wr_fire, pre_fire, ref_fire;
  logic row_hit, pre_ok;

  function automatic logic [TMR_W-1:0] tick(input logic [TMR_W-1:0] v);
    tick = (v == '0) ? '0 : v - TMR_W'(1);
  endfunction

  always_comb begin
    // Transitional states whose timer has expired already behave as their
    // destination state, so the dependent command is requested at N+T.
    state_eff = state_q;
    case (state_q)
      ST_OPENING:    if (rcd_q == '0) state_eff = ST_OPEN;
      ST_CLOSING:    if (rp_q  == '0) state_eff = ST_CLOSED;
      ST_REFRESHING: if (rfc_q == '0) state_eff = ST_CLOSED;
      default: ;
    endcase

    row_hit = (bk.req_row == open_row_q);
    pre_ok  = (ras_q == '0) && (rtp_q == '0) && (wtp_q == '0);

    act_req = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    pre_req = 1'b0;
    ref_req = 1'b0;
    // Gating with rst_n drops requests the moment reset asserts.
    if (rst_n) begin
      case (state_eff)
        ST_CLOSED: begin
          if (bk.ref_req_in)     ref_req = 1'b1;
          else if (bk.req_valid) act_req = 1'b1;
        end
        ST_OPEN: begin
          // A pending refresh or a row miss blocks column access to this row.
          if (bk.ref_req_in || (bk.req_valid && !row_hit)) begin
            pre_req = pre_ok;
          end else if (bk.req_valid) begin
            rd_req = !bk.req_wr;
            wr_req = bk.req_wr;
          end
        end
        default: ;
      endcase
    end

    act_fire = act_req && bk.act_gnt;
    rd_fire  = rd_req  && bk.rd_gnt;
    wr_fire  = wr_req  && bk.wr_gnt;
    pre_fire = pre_req && bk.pre_gnt;
    ref_fire = ref_req && bk.ref_gnt;

    state_d    = state_eff;
    open_row_d = open_row_q;
    rcd_d      = tick(rcd_q);
    ras_d      = tick(ras_q);
    rp_d       = tick(rp_q);
    rtp_d      = tick(rtp_q);
    wtp_d      = tick(wtp_q);
    rfc_d      = tick(rfc_q);

    if (act_fire) begin
      state_d    = ST_OPENING;
      open_row_d = bk.req_row;
      rcd_d      = LD_RCD;
      ras_d      = LD_RAS;
    end
    if (ref_fire) begin
      state_d = ST_REFRESHING;
      rfc_d   = LD_RFC;
    end
    if (rd_fire) rtp_d = LD_RTP;
    if (wr_fire) wtp_d = LD_WTP;
    if (pre_fire) begin
      state_d = ST_CLOSING;
      rp_d    = LD_RP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLOSED;
      open_row_q <= '0;
      rcd_q      <= '0;
      ras_q      <= '0;
      rp_q       <= '0;
      rtp_q      <= '0;
      wtp_q      <= '0;
      rfc_q      <= '0;
    end else begin
      state_q    <= state_d;
      open_row_q <= open_row_d;
      rcd_q      <= rcd_d;
      ras_q      <= ras_d;
      rp_q       <= rp_d;
      rtp_q      <= rtp_d;
      wtp_q      <= wtp_d;
      rfc_q      <= rfc_d;
    end
  end

  assign bk.act_req   = act_req;
  assign bk.rd_req    = rd_req;
  assign bk.wr_req    = wr_req;
  assign bk.pre_req   = pre_req;
  assign bk.ref_req   = ref_req;
  assign bk.act_row   = act_req ? bk.req_row : '0;
  // Stray grants are ignored, so acknowledges only follow real issues.
  assign bk.req_ready = rd_fire || wr_fire;
  assign bk.ref_ack   = ref_fire;

`ifndef SYNTHESIS
  a_gnt_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    !((bk.act_gnt && !act_req) || (bk.rd_gnt && !rd_req) || (bk.wr_gnt && !wr_req) ||
      (bk.pre_gnt && !pre_req) || (bk.ref_gnt && !ref_req)));
  a_one_req: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({act_req, rd_req, wr_req, pre_req, ref_req}));
`endif

endmodule
`default_nettype wire
